// File: rtl/pipe_field_pkg.sv
// rtl/pipe_field_pkg.sv - shared state codes and constants for the pipe field
package pipe_field_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  localparam int INVALID_Y = -1;

endpackage

// File: rtl/scroll_tick_divider.sv
// rtl/scroll_tick_divider.sv - run-gated clock divider producing the scroll tick strobe
module scroll_tick_divider #(
  parameter int DIVIDER = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] count;

  // Strobe is combinational so pipe updates land on the very edge the counter wraps.
  assign tick = run && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_field_controller.sv
// rtl/pipe_field_controller.sv - scrolling pipe field with fill, recycle and pass scoring
module pipe_field_controller
  import pipe_field_pkg::*;
#(
  parameter int NUM_PIPES     = 3,
  parameter int COORD_W       = 12,
  parameter int SCREEN_WIDTH  = 640,
  parameter int PIPE_WIDTH    = 52,
  parameter int PIPE_DISTANCE = 275,
  parameter int Y_MIN         = 100,
  parameter int Y_RANGE       = 195,
  parameter int BIRD_X        = 120,
  parameter int TIMER_DIVIDER = 50000,
  parameter int SCORE_W       = 10
) (
  input  logic                         iClock,
  input  logic                         iResetN,
  input  logic [1:0]                   iState,
  input  logic [31:0]                  iRandomNumber,
  input  logic [2:0]                   iSpeed,
  output logic [NUM_PIPES*COORD_W-1:0] oPipeX,
  output logic [NUM_PIPES*COORD_W-1:0] oPipeY,
  output logic [NUM_PIPES-1:0]         oValid,
  output logic                         oPassPulse,
  output logic [SCORE_W-1:0]           oScore
);

  localparam int IW = $clog2(NUM_PIPES);

  typedef logic signed [COORD_W-1:0] coord_t;

  localparam coord_t DIST_C  = coord_t'(PIPE_DISTANCE);
  localparam coord_t WIDTH_C = coord_t'(PIPE_WIDTH);
  localparam coord_t BIRD_C  = coord_t'(BIRD_X);
  localparam coord_t LIMIT_C = coord_t'(-PIPE_WIDTH);
  localparam coord_t Y_MIN_C = coord_t'(Y_MIN);
  localparam logic [31:0] Y_RANGE_W = 32'(Y_RANGE);

  if (NUM_PIPES < 2 || NUM_PIPES > 8 ||
      SCREEN_WIDTH + NUM_PIPES * PIPE_DISTANCE >= 2 ** (COORD_W - 1)) begin : g_param_check
    $error("pipe_field_controller: parameters out of range for COORD_W");
  end

  state_t st;
  logic   tick;
  coord_t step, rand_q, rand_next;
  coord_t x_q [NUM_PIPES];
  coord_t y_q [NUM_PIPES];
  coord_t x_nxt [NUM_PIPES];
  coord_t y_nxt [NUM_PIPES];
  logic [NUM_PIPES-1:0] valid_q, valid_nxt, below, pass_vec;
  logic                 fill_hit, rec_hit;
  logic [IW-1:0]        fill_idx, rec_idx;
  logic [15:0]          rand_scaled;
  logic                 pass_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 unused_rand_hi;

  assign st = state_t'(iState);
  assign unused_rand_hi = ^iRandomNumber[31:16];

  scroll_tick_divider #(
    .DIVIDER(TIMER_DIVIDER)
  ) u_tick (
    .clk  (iClock),
    .rst_n(iResetN),
    .run  (st == ST_RUN),
    .clear(st == ST_IDLE),
    .tick (tick)
  );

  // Scale-by-multiply keeps the gap centre uniform-ish without a divider.
  assign rand_scaled = 16'(({16'd0, iRandomNumber[15:0]} * Y_RANGE_W) >> 16);
  assign rand_next   = coord_t'(rand_scaled) + Y_MIN_C;
  assign step        = tick ? coord_t'({1'b0, iSpeed}) : '0;

  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    rec_hit  = 1'b0;
    rec_idx  = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        fill_hit = 1'b1;
        fill_idx = IW'(i);
      end
      if (below[i]) begin
        rec_hit = 1'b1;
        rec_idx = IW'(i);
      end
    end
    if (fill_hit) begin
      rec_hit = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
    localparam int PRED = (g + NUM_PIPES - 1) % NUM_PIPES;
    logic is_fill, is_rec;

    assign below[g]  = x_q[g] < LIMIT_C;
    assign is_fill   = fill_hit && (fill_idx == IW'(g));
    assign is_rec    = rec_hit && (rec_idx == IW'(g));
    // Recycled pipe lands behind its predecessor's post-tick position, keeping spacing exact.
    assign x_nxt[g]     = is_rec ? (x_q[PRED] + DIST_C - step) : (x_q[g] - step);
    assign y_nxt[g]     = (is_rec || is_fill) ? rand_q : y_q[g];
    assign valid_nxt[g] = valid_q[g] | is_fill;
    assign pass_vec[g]  = tick && valid_q[g] && !is_rec &&
                          (x_q[g] + WIDTH_C >= BIRD_C) &&
                          (x_q[g] - step + WIDTH_C < BIRD_C);

    assign oPipeX[g*COORD_W +: COORD_W] = x_q[g];
    assign oPipeY[g*COORD_W +: COORD_W] = y_q[g];
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= coord_t'(SCREEN_WIDTH + i * PIPE_DISTANCE);
        y_q[i] <= coord_t'(INVALID_Y);
      end
      valid_q <= '0;
      pass_q  <= 1'b0;
      score_q <= '0;
      rand_q  <= Y_MIN_C;
    end else begin
      case (st)
        ST_IDLE: begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= coord_t'(SCREEN_WIDTH + i * PIPE_DISTANCE);
            y_q[i] <= coord_t'(INVALID_Y);
          end
          valid_q <= '0;
          pass_q  <= 1'b0;
          score_q <= '0;
          rand_q  <= Y_MIN_C;
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= x_nxt[i];
            y_q[i] <= y_nxt[i];
          end
          valid_q <= valid_nxt;
          pass_q  <= |pass_vec;
          if (|pass_vec && score_q != '1) begin
            score_q <= score_q + 1'b1;
          end
          rand_q <= rand_next;
        end
        default: begin
          pass_q <= 1'b0;
          rand_q <= rand_next;
        end
      endcase
    end
  end

  assign oValid     = valid_q;
  assign oPassPulse = pass_q;
  assign oScore     = score_q;

endmodule

// File: tb/tb_pipe_field_controller.sv
// tb/tb_pipe_field_controller.sv - table-driven scoreboard bench for pipe_field_controller
module tb_pipe_field_controller;

  logic        iClock = 1'b0;
  logic        iResetN = 1'b1;
  logic [1:0]  iState = 2'd0;
  logic [31:0] iRandomNumber = 32'h0;
  logic [2:0]  iSpeed = 3'd0;
  logic [35:0] oPipeX, oPipeY;
  logic [2:0]  oValid;
  logic        oPassPulse;
  logic [1:0]  oScore;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_field_controller #(
    .TIMER_DIVIDER(4),
    .SCORE_W(2)
  ) dut (
    .iClock       (iClock),
    .iResetN      (iResetN),
    .iState       (iState),
    .iRandomNumber(iRandomNumber),
    .iSpeed       (iSpeed),
    .oPipeX       (oPipeX),
    .oPipeY       (oPipeY),
    .oValid       (oValid),
    .oPassPulse   (oPassPulse),
    .oScore       (oScore)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [1:0]  st;
    logic [2:0]  spd;
    logic [31:0] rnd;
    int          ncyc;
    int          x0, x1, x2;
    int          valid;
    int          pulse;
    int          score;
    int          y0;
  } vec_t;

  vec_t tbl[15];
  vec_t exp_q[$];

  function automatic int get_x(int i);
    logic signed [11:0] v;
    v = oPipeX[i*12 +: 12];
    return int'(v);
  endfunction

  function automatic int get_y(int i);
    logic signed [11:0] v;
    v = oPipeY[i*12 +: 12];
    return int'(v);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge iClock);
    #1;
  endtask

  task automatic chk_y_range(input string name);
    for (int i = 0; i < 3; i++) begin
      chk(name, int'(get_y(i) >= 100 && get_y(i) <= 294), 1);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_x0"}, get_x(0), 640);
    chk({name, "_x1"}, get_x(1), 915);
    chk({name, "_x2"}, get_x(2), 1190);
    chk({name, "_y0"}, get_y(0), -1);
    chk({name, "_y2"}, get_y(2), -1);
    chk({name, "_valid"}, int'(oValid), 0);
    chk({name, "_pulse"}, int'(oPassPulse), 0);
    chk({name, "_score"}, int'(oScore), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // Speed-3 run rows are timed from a zero tick count with X = 624/899/1174.
    tbl[0]  = '{2'd1, 3'd1, 32'h8000,  40,  630,  905, 1180, 7, 0, 0, 100};
    tbl[1]  = '{2'd2, 3'd3, 32'h1234, 100,  630,  905, 1180, 7, 0, 0, 100};
    tbl[2]  = '{2'd3, 3'd3, 32'hFFFF,  50,  630,  905, 1180, 7, 0, 0, 100};
    tbl[3]  = '{2'd1, 3'd3, 32'h8000,   1,  627,  902, 1177, 7, 0, 0, 100};
    tbl[4]  = '{2'd1, 3'd3, 32'h8000,   3,  627,  902, 1177, 7, 0, 0, 100};
    tbl[5]  = '{2'd1, 3'd3, 32'h8000,   1,  624,  899, 1174, 7, 0, 0, 100};
    tbl[6]  = '{2'd1, 3'd3, 32'h8000, 740,   69,  344,  619, 7, 0, 0, 100};
    tbl[7]  = '{2'd1, 3'd3, 32'h8000,   4,   66,  341,  616, 7, 1, 1, 100};
    tbl[8]  = '{2'd1, 3'd3, 32'h8000,   1,   66,  341,  616, 7, 0, 1, 100};
    tbl[9]  = '{2'd1, 3'd3, 32'h8000, 159,  -54,  221,  496, 7, 0, 1, 100};
    tbl[10] = '{2'd1, 3'd3, 32'h8000,   1,  771,  221,  496, 7, 0, 1, 197};
    tbl[11] = '{2'd1, 3'd3, 32'h8000, 207,  615,   65,  340, 7, 1, 2, 197};
    tbl[12] = '{2'd1, 3'd3, 32'h8000, 364,  342,  617,   67, 7, 1, 3, 197};
    tbl[13] = '{2'd1, 3'd3, 32'h8000, 368,   66,  341,  616, 7, 1, 3, 197};
    tbl[14] = '{2'd2, 3'd3, 32'h8000,   1,   66,  341,  616, 7, 0, 3, 197};

    // Asynchronous reset before any clock edge.
    #2 iResetN = 1'b0;
    #1 chk_reset_vals("reset");
    iResetN = 1'b1;
    iRandomNumber = 32'hFFFF;
    clocks(3);
    chk_reset_vals("idle");

    // Fill: one pipe per edge, Y taken from the rand register of the previous cycle.
    iState = 2'd1;
    clocks(1);
    chk("fill1_valid", int'(oValid), 1);
    chk("fill1_y0", get_y(0), 100);
    chk("fill1_y1", get_y(1), -1);
    iRandomNumber = 32'h8000;
    clocks(1);
    chk("fill2_valid", int'(oValid), 3);
    chk("fill2_y1", get_y(1), 294);
    clocks(1);
    chk("fill3_valid", int'(oValid), 7);
    chk("fill3_y2", get_y(2), 197);
    chk("fill3_x0", get_x(0), 640);
    chk("fill3_x1", get_x(1), 915);
    chk("fill3_x2", get_x(2), 1190);
    chk_y_range("fill_yrange");

    for (int k = 0; k < 15; k++) begin
      iState = tbl[k].st;
      iSpeed = tbl[k].spd;
      iRandomNumber = tbl[k].rnd;
      exp_q.push_back(tbl[k]);
      clocks(tbl[k].ncyc);
      if (exp_q.size() == 0) begin
        chk($sformatf("row%0d_scoreboard_empty", k), 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d_x0", k), get_x(0), e.x0);
        chk($sformatf("row%0d_x1", k), get_x(1), e.x1);
        chk($sformatf("row%0d_x2", k), get_x(2), e.x2);
        chk($sformatf("row%0d_spacing", k), get_x(1) - get_x(0) == 275 ||
            get_x(2) - get_x(1) == 275 ? 1 : 0, 1);
        chk($sformatf("row%0d_valid", k), int'(oValid), e.valid);
        chk($sformatf("row%0d_pulse", k), int'(oPassPulse), e.pulse);
        chk($sformatf("row%0d_score", k), int'(oScore), e.score);
        chk($sformatf("row%0d_y0", k), get_y(0), e.y0);
        chk_y_range($sformatf("row%0d_yrange", k));
      end
    end

    // Asynchronous reset mid-run, away from any clock edge.
    iState = 2'd1;
    clocks(5);
    #2 iResetN = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    clocks(1);
    chk_reset_vals("held_reset");
    #2 iResetN = 1'b1;
    iState = 2'd0;
    clocks(2);
    chk_reset_vals("post_reset_idle");

    iState = 2'd1;
    iSpeed = 3'd3;
    iRandomNumber = 32'h0;
    clocks(1);
    chk("refill1_valid", int'(oValid), 1);
    clocks(1);
    chk("refill2_valid", int'(oValid), 3);
    chk("refill2_y1", get_y(1), 100);
    clocks(1);
    chk("refill3_valid", int'(oValid), 7);
    chk("refill3_x0_no_tick", get_x(0), 640);
    clocks(1);
    chk("first_tick_x0", get_x(0), 637);
    chk("first_tick_x2", get_x(2), 1187);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
